// File: rtl/mdu_sequencer.sv
// Iterative MUL / DIVU / REMU sequencer that borrows the core's shared ALU.
// Each operation takes 32 RUN iterations plus one DONE cycle.
module mdu_sequencer #(
    parameter int         XLEN    = 32,
    parameter int         CNT_W   = 5,
    parameter logic [3:0] ALU_ADD = 4'd0,
    parameter logic [3:0] ALU_SUB = 4'd1
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic            Start,
    input  logic [1:0]      Op,
    input  logic [XLEN-1:0] Rs1,
    input  logic [XLEN-1:0] Rs2,
    output logic            Busy,
    output logic            Done,
    output logic [XLEN-1:0] Result,
    output logic [3:0]      Alu_Sel,
    output logic [XLEN-1:0] Alu_Op_1,
    output logic [XLEN-1:0] Alu_Op_2,
    input  logic [XLEN-1:0] Alu_Result,
    input  logic            Alu_Bigger,
    input  logic            Alu_Equal
);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [1:0]        op_q, op_d;
    // Working registers are shared: acc/rem, mcand/quo, mplier/dvsr.
    logic [XLEN-1:0]   acc_rem_q, acc_rem_d;
    logic [XLEN-1:0]   mcand_quo_q, mcand_quo_d;
    logic [XLEN-1:0]   mplier_dvsr_q, mplier_dvsr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              is_mul;
    logic [XLEN-1:0]   div_sh;
    logic              div_ge;

    assign is_mul = (op_q == OP_MUL);
    assign div_sh = {acc_rem_q[XLEN-2:0], mcand_quo_q[XLEN-1]};
    // The shifted-out rem MSB means the 33-bit partial remainder already exceeds dvsr.
    assign div_ge = acc_rem_q[XLEN-1] | Alu_Bigger | Alu_Equal;

    always_comb begin
        Alu_Sel  = ALU_ADD;
        Alu_Op_1 = '0;
        Alu_Op_2 = '0;
        if (state_q == S_RUN) begin
            if (is_mul) begin
                Alu_Sel  = ALU_ADD;
                Alu_Op_1 = acc_rem_q;
                Alu_Op_2 = mcand_quo_q;
            end else begin
                Alu_Sel  = ALU_SUB;
                Alu_Op_1 = div_sh;
                Alu_Op_2 = mplier_dvsr_q;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        op_d          = op_q;
        acc_rem_d     = acc_rem_q;
        mcand_quo_d   = mcand_quo_q;
        mplier_dvsr_d = mplier_dvsr_q;
        result_d      = result_q;
        case (state_q)
            S_IDLE: begin
                if (Start && (Op != OP_RSVD)) begin
                    state_d       = S_RUN;
                    count_d       = '0;
                    op_d          = Op;
                    acc_rem_d     = '0;
                    mcand_quo_d   = Rs1;
                    mplier_dvsr_d = Rs2;
                end
            end
            S_RUN: begin
                if (is_mul) begin
                    if (mplier_dvsr_q[0]) begin
                        acc_rem_d = Alu_Result;
                    end
                    mcand_quo_d   = mcand_quo_q << 1;
                    mplier_dvsr_d = mplier_dvsr_q >> 1;
                end else begin
                    acc_rem_d   = div_ge ? Alu_Result : div_sh;
                    mcand_quo_d = {mcand_quo_q[XLEN-2:0], div_ge};
                end
                count_d = count_q + 1'b1;
                if (count_q == CNT_W'(XLEN - 1)) begin
                    state_d  = S_DONE;
                    result_d = (op_q == OP_DIVU) ? mcand_quo_d : acc_rem_d;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            op_q          <= '0;
            acc_rem_q     <= '0;
            mcand_quo_q   <= '0;
            mplier_dvsr_q <= '0;
            result_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            op_q          <= op_d;
            acc_rem_q     <= acc_rem_d;
            mcand_quo_q   <= mcand_quo_d;
            mplier_dvsr_q <= mplier_dvsr_d;
            result_q      <= result_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign Busy   = busy_q;
    assign Done   = done_q;
    assign Result = result_q;

endmodule
